// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit plus PC register for the newStep3 datapath; Moore strobes decoded from state.
// Latency: 2-5 cycles per instruction (FETCH, DECODE, then opcode-specific steps); PC updates at the FETCH/BRANCH/JUMP edge.
// Backpressure: none; the sequencer advances every cycle and reset aborts an instruction immediately.
module multicycle_control_fsm #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] PC_RESET = '0,
  parameter int                  PC_STEP  = 1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [3:0]          Op,
  input  logic                compOut,
  input  logic [PC_WIDTH-1:0] ALUOut,
  output logic [PC_WIDTH-1:0] PC,
  output logic                memAddrSel,
  output logic                memEnableRead,
  output logic                memEnableWrite,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic [2:0]          ALUOp,
  output logic [1:0]          numBits,
  output logic [1:0]          immShift,
  output logic                writeEnable,
  output logic [2:0]          regDataWrite,
  output logic                outWrite,
  output logic                illegalOp
);

  // EXEC_I and BRANCH are split per opcode so Op is never needed after DECODE.
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_ADDI,
    EXEC_LOAD,
    EXEC_STORE,
    MEM_RD,
    MEM_WR,
    WB_ALU,
    WB_MEM,
    WB_IN,
    BRANCH_EQ,
    BRANCH_NE,
    JUMP,
    OUT
  } state_t;

  state_t              state;
  state_t              stateNext;
  logic [PC_WIDTH-1:0] pcNext;
  logic [2:0]          opLatched;
  logic                opIllegal;

  assign opIllegal = (Op == 4'h5) || (Op >= 4'hD);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      PC        <= PC_RESET;
      opLatched <= '0;
    end else begin
      state <= stateNext;
      PC    <= pcNext;
      if (state == DECODE) begin
        opLatched <= Op[2:0];
      end
    end
  end

  always_comb begin
    stateNext = FETCH;
    pcNext    = PC;
    case (state)
      FETCH: begin
        stateNext = DECODE;
        pcNext    = PC + PC_WIDTH'(PC_STEP);
      end
      DECODE: begin
        case (Op)
          4'h0, 4'h1, 4'h2, 4'h3: stateNext = EXEC_R;
          4'h4:                   stateNext = EXEC_ADDI;
          4'h6:                   stateNext = EXEC_LOAD;
          4'h7:                   stateNext = EXEC_STORE;
          4'h8:                   stateNext = BRANCH_EQ;
          4'h9:                   stateNext = BRANCH_NE;
          4'hA:                   stateNext = JUMP;
          4'hB:                   stateNext = WB_IN;
          4'hC:                   stateNext = OUT;
          default:                stateNext = FETCH;
        endcase
      end
      EXEC_R:     stateNext = WB_ALU;
      EXEC_ADDI:  stateNext = WB_ALU;
      EXEC_LOAD:  stateNext = MEM_RD;
      EXEC_STORE: stateNext = MEM_WR;
      MEM_RD:     stateNext = WB_MEM;
      BRANCH_EQ: begin
        if (compOut) begin
          pcNext = ALUOut;
        end
      end
      BRANCH_NE: begin
        if (!compOut) begin
          pcNext = ALUOut;
        end
      end
      JUMP:       pcNext = ALUOut;
      default:    stateNext = FETCH;
    endcase
  end

  always_comb begin
    memAddrSel     = 1'b0;
    memEnableRead  = 1'b0;
    memEnableWrite = 1'b0;
    IRWrite        = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 1'b0;
    ALUOp          = 3'b000;
    numBits        = 2'd0;
    immShift       = 2'd0;
    writeEnable    = 1'b0;
    regDataWrite   = 3'b000;
    outWrite       = 1'b0;
    illegalOp      = 1'b0;
    case (state)
      FETCH: begin
        memEnableRead = 1'b1;
        IRWrite       = 1'b1;
      end
      DECODE: begin
        ALUSrcB   = 1'b1;
        immShift  = 2'd1;
        numBits   = 2'd3;
        illegalOp = opIllegal;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = opLatched;
      end
      EXEC_ADDI, EXEC_LOAD, EXEC_STORE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 1'b1;
        numBits = 2'd1;
      end
      MEM_RD: begin
        memAddrSel    = 1'b1;
        memEnableRead = 1'b1;
      end
      MEM_WR: begin
        memAddrSel     = 1'b1;
        memEnableWrite = 1'b1;
      end
      WB_ALU: writeEnable = 1'b1;
      WB_MEM: begin
        writeEnable  = 1'b1;
        regDataWrite = 3'b001;
      end
      WB_IN: begin
        writeEnable  = 1'b1;
        regDataWrite = 3'b010;
      end
      BRANCH_EQ, BRANCH_NE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b001;
      end
      OUT:     outWrite = 1'b1;
      default: ;
    endcase
    // Strobes must drop the instant reset rises, not at the next edge.
    if (reset) begin
      memAddrSel     = 1'b0;
      memEnableRead  = 1'b0;
      memEnableWrite = 1'b0;
      IRWrite        = 1'b0;
      ALUSrcA        = 1'b0;
      ALUSrcB        = 1'b0;
      ALUOp          = 3'b000;
      numBits        = 2'd0;
      immShift       = 2'd0;
      writeEnable    = 1'b0;
      regDataWrite   = 3'b000;
      outWrite       = 1'b0;
      illegalOp      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: instruction table, reset/wrap corner cases,
// and a randomized run against an instruction-level reference model.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       memAddrSel;
    logic       memEnableRead;
    logic       memEnableWrite;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] numBits;
    logic [1:0] immShift;
    logic       writeEnable;
    logic [2:0] regDataWrite;
    logic       outWrite;
    logic       illegalOp;
  } ctl_t;

  typedef struct {
    logic [3:0]  op;
    logic        cmp;
    logic [15:0] alu;
    int          expLen;
    logic [15:0] expPc;
    int          expWr;
    int          expIll;
  } vec_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  Op = 4'hE;
  logic        compOut = 1'b0;
  logic [15:0] ALUOut = 16'h0;
  logic [15:0] PC;
  logic        memAddrSel, memEnableRead, memEnableWrite, IRWrite, ALUSrcA, ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  numBits, immShift;
  logic        writeEnable;
  logic [2:0]  regDataWrite;
  logic        outWrite, illegalOp;
  ctl_t        dutCtl;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(.PC_WIDTH(16), .PC_RESET(16'h0000), .PC_STEP(1)) dut (
    .CLK(CLK), .reset(reset), .Op(Op), .compOut(compOut), .ALUOut(ALUOut), .PC(PC),
    .memAddrSel(memAddrSel), .memEnableRead(memEnableRead), .memEnableWrite(memEnableWrite),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .numBits(numBits), .immShift(immShift), .writeEnable(writeEnable),
    .regDataWrite(regDataWrite), .outWrite(outWrite), .illegalOp(illegalOp)
  );

  assign dutCtl = {memAddrSel, memEnableRead, memEnableWrite, IRWrite, ALUSrcA, ALUSrcB,
                   ALUOp, numBits, immShift, writeEnable, regDataWrite, outWrite, illegalOp};

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int instrLen(input logic [3:0] op);
    if (op <= 4'h4) return 4;
    if (op == 4'h6) return 5;
    if (op == 4'h7) return 4;
    if (op >= 4'h8 && op <= 4'hC) return 3;
    return 2;
  endfunction

  // Expected strobes for cycle idx of an instruction (0 = fetch, 1 = decode).
  function automatic ctl_t expCtl(input logic [3:0] op, input int idx);
    ctl_t c;
    c = '0;
    if (idx == 0) begin
      c.memEnableRead = 1'b1;
      c.IRWrite       = 1'b1;
    end else if (idx == 1) begin
      c.ALUSrcB   = 1'b1;
      c.immShift  = 2'd1;
      c.numBits   = 2'd3;
      c.illegalOp = (instrLen(op) == 2);
    end else begin
      case (op)
        4'h0, 4'h1, 4'h2, 4'h3: begin
          if (idx == 2) begin c.ALUSrcA = 1'b1; c.ALUOp = op[2:0]; end
          else c.writeEnable = 1'b1;
        end
        4'h4, 4'h6, 4'h7: begin
          if (idx == 2) begin c.ALUSrcA = 1'b1; c.ALUSrcB = 1'b1; c.numBits = 2'd1; end
          else if (op == 4'h4) c.writeEnable = 1'b1;
          else if (op == 4'h7) begin c.memAddrSel = 1'b1; c.memEnableWrite = 1'b1; end
          else if (idx == 3) begin c.memAddrSel = 1'b1; c.memEnableRead = 1'b1; end
          else begin c.writeEnable = 1'b1; c.regDataWrite = 3'b001; end
        end
        4'h8, 4'h9: begin c.ALUSrcA = 1'b1; c.ALUOp = 3'b001; end
        4'hB: begin c.writeEnable = 1'b1; c.regDataWrite = 3'b010; end
        4'hC: c.outWrite = 1'b1;
        default: ;
      endcase
    end
    return c;
  endfunction

  // Leaves the bench just after a negedge with the DUT in FETCH and PC = 0.
  task automatic pulseReset();
    @(negedge CLK);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic nextCycle();
    @(negedge CLK);
    #1;
  endtask

  vec_t vecs[15];

  initial begin
    int len, wr, il;
    bit done;
    int idx;
    logic [3:0] mOp;
    logic [15:0] mPc;

    vecs[0]  = '{4'h0, 1'b0, 16'h0000, 4, 16'h0001, 1, 0};
    vecs[1]  = '{4'h3, 1'b0, 16'h0000, 4, 16'h0001, 1, 0};
    vecs[2]  = '{4'h4, 1'b0, 16'h0000, 4, 16'h0001, 1, 0};
    vecs[3]  = '{4'h6, 1'b0, 16'h0000, 5, 16'h0001, 1, 0};
    vecs[4]  = '{4'h7, 1'b0, 16'h0000, 4, 16'h0001, 1, 0};
    vecs[5]  = '{4'h8, 1'b1, 16'h0020, 3, 16'h0020, 0, 0};
    vecs[6]  = '{4'h8, 1'b0, 16'h0020, 3, 16'h0001, 0, 0};
    vecs[7]  = '{4'h9, 1'b0, 16'h0030, 3, 16'h0030, 0, 0};
    vecs[8]  = '{4'h9, 1'b1, 16'h0030, 3, 16'h0001, 0, 0};
    vecs[9]  = '{4'hA, 1'b0, 16'h1234, 3, 16'h1234, 0, 0};
    vecs[10] = '{4'hB, 1'b0, 16'h0000, 3, 16'h0001, 1, 0};
    vecs[11] = '{4'hC, 1'b0, 16'h0000, 3, 16'h0001, 0, 0};
    vecs[12] = '{4'h5, 1'b0, 16'h0000, 2, 16'h0001, 0, 1};
    vecs[13] = '{4'hE, 1'b0, 16'h0000, 2, 16'h0001, 0, 1};
    vecs[14] = '{4'hF, 1'b0, 16'h0000, 2, 16'h0001, 0, 1};

    // Held in reset across clock edges: everything quiet, PC at reset value.
    #1;
    check("reset_ctl", {13'b0, dutCtl}, 32'h0);
    check("reset_pc", {16'b0, PC}, 32'h0);
    nextCycle();
    nextCycle();
    check("reset_ctl_held", {13'b0, dutCtl}, 32'h0);
    check("reset_pc_held", {16'b0, PC}, 32'h0);
    @(negedge CLK);
    reset = 1'b0;
    Op = 4'h0;
    #1;
    check("first_fetch", {13'b0, dutCtl}, {13'b0, expCtl(4'h0, 0)});

    foreach (vecs[v]) begin
      pulseReset();
      Op = vecs[v].op;
      compOut = vecs[v].cmp;
      ALUOut = vecs[v].alu;
      #1;
      len = 0; wr = 0; il = 0; done = 1'b0;
      for (int k = 0; k < 10 && !done; k++) begin
        if (k > 0 && IRWrite) begin
          done = 1'b1;
        end else begin
          len++;
          wr += int'(writeEnable | memEnableWrite);
          il += int'(illegalOp);
          nextCycle();
        end
      end
      check($sformatf("vec%0d_len", v), len, vecs[v].expLen);
      check($sformatf("vec%0d_pc", v), {16'b0, PC}, {16'b0, vecs[v].expPc});
      check($sformatf("vec%0d_writes", v), wr, vecs[v].expWr);
      check($sformatf("vec%0d_illegal", v), il, vecs[v].expIll);
    end

    // Reset raised while a store is writing memory.
    pulseReset();
    Op = 4'h7;
    #1;
    nextCycle();
    nextCycle();
    nextCycle();
    check("store_memwr", {29'b0, memAddrSel, memEnableWrite, writeEnable}, 32'h6);
    reset = 1'b1;
    #1;
    check("abort_ctl", {13'b0, dutCtl}, 32'h0);
    check("abort_pc", {16'b0, PC}, 32'h0);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    check("abort_refetch", {13'b0, dutCtl}, {13'b0, expCtl(4'h7, 0)});
    check("abort_refetch_pc", {16'b0, PC}, 32'h0);
    nextCycle();
    check("abort_decode", {13'b0, dutCtl}, {13'b0, expCtl(4'h7, 1)});

    // Jump to the top of the address space, then fetch wraps PC to zero.
    pulseReset();
    Op = 4'hA;
    ALUOut = 16'hFFFF;
    #1;
    nextCycle();
    nextCycle();
    nextCycle();
    check("wrap_fetch_pc", {16'b0, PC}, 32'hFFFF);
    check("wrap_fetch_ir", {31'b0, IRWrite}, 32'h1);
    nextCycle();
    check("wrap_pc", {16'b0, PC}, 32'h0);

    // Randomized run against the instruction-level model; Op changes every cycle.
    pulseReset();
    idx = 0;
    mOp = 4'h0;
    mPc = 16'h0000;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge CLK);
      Op = 4'($urandom_range(0, 15));
      compOut = 1'($urandom_range(0, 1));
      ALUOut = 16'($urandom);
      #1;
      if (idx == 1) mOp = Op;
      check($sformatf("rnd%0d_ctl", i), {13'b0, dutCtl}, {13'b0, expCtl(mOp, idx)});
      check($sformatf("rnd%0d_pc", i), {16'b0, PC}, {16'b0, mPc});
      if (idx == 0) begin
        mPc = mPc + 16'd1;
        idx = 1;
      end else if (idx == instrLen(mOp) - 1) begin
        if ((mOp == 4'h8 && compOut) || (mOp == 4'h9 && !compOut) || mOp == 4'hA) mPc = ALUOut;
        idx = 0;
      end else begin
        idx++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
